// File: rtl/alu_io_pkg.sv
// Shared ALU I/O definitions: datapath widths and operand-loader phase encoding.
// Also used by the LED result display side of the harness.
package alu_io_pkg;

  localparam int DATA_W     = 32;
  localparam int ALU_CTRL_W = 6;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CTRL = 2'd2,
    S_FIRE = 2'd3
  } phase_e;

  // Phase reached by a "next" press; S_FIRE is left unconditionally, never by a press.
  function automatic phase_e next_phase(input phase_e cur);
    case (cur)
      S_A:     return S_B;
      S_B:     return S_CTRL;
      default: return S_FIRE;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// ALU operand bus: operands, control word, completion strobe and phase status.
interface alu_op_if;
  import alu_io_pkg::*;

  logic [DATA_W-1:0]     operand_a;
  logic [DATA_W-1:0]     operand_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  op_valid;
  logic [1:0]            phase;

  modport master (output operand_a, operand_b, alu_ctrl, op_valid, phase);
  modport slave  (input  operand_a, operand_b, alu_ctrl, op_valid, phase);

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-count debouncer and
// one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments let the synchronizer stages shift in one
  // edge regardless of statement order; blocking would collapse them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Level accepted after DEBOUNCE_CYCLES consecutive differing samples.
        level <= sync_q2;
        press <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Switch/button operand loader for the ALU test harness: builds A, B and the
// control word phase by phase, then strobes op_valid for one cycle.
module alu_operand_loader
  import alu_io_pkg::*;
#(
  parameter int SW_W            = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  input  logic            btn_load,
  input  logic            btn_next,
  alu_op_if.master        bus
);

  logic load_press;
  logic next_press;
  logic load_level_unused;
  logic next_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_load),
    .level (load_level_unused),
    .press (load_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_next),
    .level (next_level_unused),
    .press (next_press)
  );

  phase_e                state;
  logic                  first;
  logic [DATA_W-1:0]     operand_a;
  logic [DATA_W-1:0]     operand_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  op_valid;
  logic [DATA_W-1:0]     sw_ext;

  assign sw_ext = DATA_W'(sw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_A;
      first     <= 1'b1;
      operand_a <= '0;
      operand_b <= '0;
      alu_ctrl  <= '0;
      op_valid  <= 1'b0;
    end else if (state == S_FIRE) begin
      // Single fire cycle; any press pulse arriving now is dropped.
      state    <= S_A;
      first    <= 1'b1;
      op_valid <= 1'b0;
    end else begin
      if (load_press) begin
        first <= 1'b0;
        case (state)
          S_A:     operand_a <= first ? sw_ext : ((operand_a << SW_W) | sw_ext);
          S_B:     operand_b <= first ? sw_ext : ((operand_b << SW_W) | sw_ext);
          default: alu_ctrl  <= sw_ext[ALU_CTRL_W-1:0];
        endcase
      end
      // A same-cycle next press overrides the first-flag clear above.
      if (next_press) begin
        state <= next_phase(state);
        first <= 1'b1;
      end
      op_valid <= next_press && (state == S_CTRL);
    end
  end

  assign bus.operand_a = operand_a;
  assign bus.operand_b = operand_b;
  assign bus.alu_ctrl  = alu_ctrl;
  assign bus.op_valid  = op_valid;
  assign bus.phase     = state;

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Board-side input front end for the ALU FPGA test harness: the writer that feeds the ALU, opposite the LED result display. It builds operand A, operand B and the 6-bit ALU control word from slide switches and two push buttons, then issues a one-cycle `op_valid` strobe. Operands are presented in place of hardcoded constants; the existing result-to-LED path is unchanged.

## Interface
Parameters:
- `SW_W`, 8, switch bank width; legal values 4, 8, 16.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a button level change; benches use 4.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `sw`  in  SW_W  raw switch value, treated as quasi-static
- `btn_load`  in  1  raw, asynchronous, bouncing "load switches" button
- `btn_next`  in  1  raw, asynchronous, bouncing "advance phase" button
- `operand_a`  out  32  ALU operand A
- `operand_b`  out  32  ALU operand B
- `alu_ctrl`  out  6  ALU operation code
- `op_valid`  out  1  one-cycle strobe: operands and control are complete
- `phase`  out  2  current FSM state, intended for status LEDs

## Operation
- Each button path: 2-FF synchronizer, then debouncer. The debounced level flips after the synchronized input differs from it for exactly `DEBOUNCE_CYCLES` consecutive cycles. The counter clears whenever the synchronized input equals the level. Press pulse = level rising edge, one cycle wide. Releases produce no pulse.
- FSM states and encodings: `S_A`=0, `S_B`=1, `S_CTRL`=2, `S_FIRE`=3.
- `first` flag: set on entry to `S_A`, `S_B` and `S_CTRL`, and at reset. Cleared by the first load in a phase.
- Load in `S_A` or `S_B`:
  - if `first`, target <= zero-extended `sw`;
  - else target <= {target[31-SW_W:0], `sw`}, so bits shifted out are lost.
- Load in `S_CTRL`: `alu_ctrl` <= `sw[5:0]` (zero-extended if SW_W=4). Always overwrites.
- Next press: `S_A`->`S_B`->`S_CTRL`->`S_FIRE`.
- `S_FIRE` lasts exactly one cycle: `op_valid`=1, then unconditional return to `S_A`.
- Load and next pulses in the same cycle: the load is applied to the current phase's target, then the state advances.
- Pulses arriving while in `S_FIRE` are dropped.
- Operands and `alu_ctrl` hold their values across `S_FIRE` and into the next round until reloaded.
- Reset (any time, including mid-debounce): all outputs 0, state `S_A`, `first`=1, synchronizers, levels and counters 0. No press pulse is generated when reset releases with a button held; the held button must first satisfy the debounce rule.

## Timing
- Raw button edge, held stable: first sampled at edge 1, synchronized at edge 2, level flips at edge 2+`DEBOUNCE_CYCLES`, register update at edge 3+`DEBOUNCE_CYCLES`.
- With D=4, the update is visible after edge 7.
- `op_valid` is registered and high for the single cycle `phase`==3. `op_valid` and `phase` change on the same edge.
- All outputs are registered; no combinational path from any input to any output.
- Reset assertion clears outputs immediately (asynchronous). Reset deassertion is synchronous to `clk` by the board reset synchronizer.

## Structure
- Shared package `alu_io_pkg`:
  - `DATA_W`=32, `ALU_CTRL_W`=6;
  - phase encoding typedef/constants `S_A`/`S_B`/`S_CTRL`/`S_FIRE`;
  - it will be reused by the LED display side.
- Sub-module `btn_debounce` (synchronizer + counter + edge detect, parameter `DEBOUNCE_CYCLES`, outputs `level` and `press`). Instantiated twice.
- Top: FSM plus operand registers.

## Test plan
(`DEBOUNCE_CYCLES`=4, `SW_W`=8)
- Reset: assert `rst` mid-run -> all outputs 0 and `phase`=0 immediately, held through deassertion.
- Load A: `sw`=0x0A, clean load press -> `operand_a`=0x0000000A at edge 7; `sw`=0x12, press -> `operand_a`=0x00000A12.
- Bounce: `btn_load` toggling every 2 cycles for 20 cycles, then low -> no pulse, `operand_a` unchanged.
- Full round: load A=0x0A, next, B=0x02, next, ctrl=0x00, next -> `op_valid` high exactly one cycle with `phase`=3, then `phase`=0. Operands hold 0x0A/0x02, `alu_ctrl`=0.
- Simultaneous: in `S_B` holding 0x00000A12 from a prior round, `sw`=0x05, load and next pressed identically -> `operand_b`=0x00000005 (fresh load), `phase`=2 on the same edge.
- Dropped press: press arrives during `S_FIRE` -> ignored, `S_A` operand unchanged. Reset while `btn_next` is held -> no pulse after deassertion until the level is debounced.
